dma_csr_regs: RTL and testbench

Parametrised AXI4-Lite control/status register block for the DMA engine, replacing the fixed 8-register CSR stub in the top wrapper. Provides a configurable-size register file with per-register access modes (RW, RO, W1C), byte strobes, SLVERR decoding, hardware-side set/update ports and a level interrupt output. Sits between the AXI-Lite CSR port and the DMA datapath/controller.

---
 rtl/dma_csr_regs.sv | 266 ++++++++++++++++++++++++++
 tb/tb_dma_csr_regs.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_csr_regs.sv
// dma_csr_regs
//
// AXI4-Lite control/status register file for the DMA engine.
//
// Each register is RW, RO (loaded from the hardware side) or W1C
// (set from the hardware side, cleared by writing 1 from the bus).
// Byte strobes apply to RW and W1C registers. Out-of-range or misaligned
// accesses answer SLVERR and leave the register file untouched.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   axil_aw* / axil_w*    write address / write data channels
//   axil_b*               write response channel
//   axil_ar* / axil_r*    read address / read data channels
//   hw_wr, hw_wdata       hardware-side load (RO) / set (W1C), one slice per register
//   reg_q                 current register contents, one slice per register
//   reg_wr_pulse          one-cycle pulse when a bus write commits to a register
//   irq                   registered level interrupt, |(status & enable)
//   dbg_w_state           write FSM state
//   dbg_r_state           read FSM state
//
// Handshake rule for every channel: a transfer happens on the rising edge
// where both valid and ready are high; a source holds valid and its payload
// stable until that edge, and ready never depends combinationally on valid.
module dma_csr_regs #(
  parameter int                  ADDR_W       = 8,
  parameter int                  DATA_W       = 32,
  parameter int                  NUM_REGS     = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK      = 8'h10,
  parameter logic [NUM_REGS-1:0] W1C_MASK     = 8'h20,
  parameter int                  IRQ_STAT_IDX = 5,
  parameter int                  IRQ_EN_IDX   = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axil_awvalid,
  output logic                         axil_awready,
  input  logic [ADDR_W-1:0]            axil_awaddr,
  input  logic                         axil_wvalid,
  output logic                         axil_wready,
  input  logic [DATA_W-1:0]            axil_wdata,
  input  logic [DATA_W/8-1:0]          axil_wstrb,
  output logic                         axil_bvalid,
  input  logic                         axil_bready,
  output logic [1:0]                   axil_bresp,
  input  logic                         axil_arvalid,
  output logic                         axil_arready,
  input  logic [ADDR_W-1:0]            axil_araddr,
  output logic                         axil_rvalid,
  input  logic                         axil_rready,
  output logic [DATA_W-1:0]            axil_rdata,
  output logic [1:0]                   axil_rresp,
  input  logic [NUM_REGS-1:0]          hw_wr,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_wdata,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse,
  output logic                         irq,
  output logic [1:0]                   dbg_w_state,
  output logic [1:0]                   dbg_r_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;
  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  // Low while in reset and for the first cycle after it, so that all
  // readies rise on the first edge that samples rst_n high.
  logic live_q;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  logic              aw_done, w_done;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_hs, w_hs, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [DATA_W-1:0] byte_mask;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_err, bus_wr_en;

  assign axil_awready = live_q & ~aw_done & (w_state != W_RESP);
  assign axil_wready  = live_q & ~w_done  & (w_state != W_RESP);
  assign axil_bvalid  = (w_state == W_RESP);
  assign aw_hs        = axil_awvalid & axil_awready;
  assign w_hs         = axil_wvalid  & axil_wready;

  // The half captured earlier comes from its holding register, the half
  // arriving this cycle straight from the bus, so the write lands on the
  // same edge as the later handshake.
  assign wr_addr = aw_done ? aw_addr_q : axil_awaddr;
  assign wr_data = w_done  ? wdata_q   : axil_wdata;
  assign wr_strb = w_done  ? wstrb_q   : axil_wstrb;
  assign wr_idx  = wr_addr[ADDR_W-1:2];
  assign wr_err  = ({1'b0, wr_idx} >= NUM_REGS_W) || (wr_addr[1:0] != 2'b00);
  assign bus_wr_en = commit & ~wr_err;

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      byte_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    commit      = 1'b0;
    case (w_state)
      W_IDLE, W_WAIT: begin
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          commit      = 1'b1;
          w_state_nxt = W_RESP;
        end else if (aw_hs | w_hs) begin
          w_state_nxt = W_WAIT;
        end
      end
      W_RESP: begin
        if (axil_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state    <= W_IDLE;
      live_q     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      aw_addr_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      axil_bresp <= RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      live_q  <= 1'b1;
      if (commit) begin
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        axil_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_done   <= 1'b1;
          aw_addr_q <= axil_awaddr;
        end
        if (w_hs) begin
          w_done  <= 1'b1;
          wdata_q <= axil_wdata;
          wstrb_q <= axil_wstrb;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_W-1:0] q, nxt;
    logic              sel, pulse_q;
    logic [DATA_W-1:0] hw_val;

    assign sel    = bus_wr_en && (wr_idx == IDX_W'(gi));
    assign hw_val = hw_wdata[gi*DATA_W +: DATA_W];

    always_comb begin
      nxt = q;
      if (RO_MASK[gi]) begin
        if (hw_wr[gi]) nxt = hw_val;
      end else if (W1C_MASK[gi]) begin
        // Clear first, then set: a same-cycle hardware set wins.
        if (sel)       nxt = nxt & ~(wr_data & byte_mask);
        if (hw_wr[gi]) nxt = nxt | hw_val;
      end else begin
        if (sel) nxt = (q & ~byte_mask) | (wr_data & byte_mask);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q       <= '0;
        pulse_q <= 1'b0;
      end else begin
        q       <= nxt;
        pulse_q <= sel;
      end
    end

    assign regs[gi]                      = q;
    assign reg_q[gi*DATA_W +: DATA_W]    = q;
    assign reg_wr_pulse[gi]              = pulse_q;
  end

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  logic              ar_hs;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_err;
  logic [DATA_W-1:0] rd_val;

  assign axil_arready = live_q & (r_state == R_IDLE);
  assign axil_rvalid  = (r_state == R_DATA);
  assign ar_hs        = axil_arvalid & axil_arready;
  assign rd_idx       = axil_araddr[ADDR_W-1:2];
  assign rd_err       = ({1'b0, rd_idx} >= NUM_REGS_W) || (axil_araddr[1:0] != 2'b00);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val = regs[i];
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)       r_state_nxt = R_DATA;
      R_DATA:  if (axil_rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      axil_rdata <= '0;
      axil_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        axil_rdata <= rd_err ? '0 : rd_val;
        axil_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Interrupt
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(regs[IRQ_STAT_IDX] & regs[IRQ_EN_IDX]);
  end

  assign dbg_w_state = w_state;
  assign dbg_r_state = {1'b0, r_state};

  // Hardware inputs of RW registers have no effect by design.
  logic unused_hw;
  assign unused_hw = ^{hw_wr, hw_wdata};

endmodule

// File: tb/tb_dma_csr_regs.sv
// tb_dma_csr_regs
//
// Directed bench for dma_csr_regs with default parameters (8 registers,
// reg4 RO, reg5 W1C status, reg6 interrupt enable). Inputs are driven 1 ns
// after the rising edge and outputs are sampled at the same point.
module tb_dma_csr_regs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         axil_awvalid, axil_awready;
  logic [7:0]   axil_awaddr;
  logic         axil_wvalid, axil_wready;
  logic [31:0]  axil_wdata;
  logic [3:0]   axil_wstrb;
  logic         axil_bvalid, axil_bready;
  logic [1:0]   axil_bresp;
  logic         axil_arvalid, axil_arready;
  logic [7:0]   axil_araddr;
  logic         axil_rvalid, axil_rready;
  logic [31:0]  axil_rdata;
  logic [1:0]   axil_rresp;
  logic [7:0]   hw_wr;
  logic [255:0] hw_wdata;
  logic [255:0] reg_q;
  logic [7:0]   reg_wr_pulse;
  logic         irq;
  logic [1:0]   dbg_w_state, dbg_r_state;

  int n_checks = 0;
  int n_errors = 0;

  dma_csr_regs dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .axil_awvalid (axil_awvalid),
    .axil_awready (axil_awready),
    .axil_awaddr  (axil_awaddr),
    .axil_wvalid  (axil_wvalid),
    .axil_wready  (axil_wready),
    .axil_wdata   (axil_wdata),
    .axil_wstrb   (axil_wstrb),
    .axil_bvalid  (axil_bvalid),
    .axil_bready  (axil_bready),
    .axil_bresp   (axil_bresp),
    .axil_arvalid (axil_arvalid),
    .axil_arready (axil_arready),
    .axil_araddr  (axil_araddr),
    .axil_rvalid  (axil_rvalid),
    .axil_rready  (axil_rready),
    .axil_rdata   (axil_rdata),
    .axil_rresp   (axil_rresp),
    .hw_wr        (hw_wr),
    .hw_wdata     (hw_wdata),
    .reg_q        (reg_q),
    .reg_wr_pulse (reg_wr_pulse),
    .irq          (irq),
    .dbg_w_state  (dbg_w_state),
    .dbg_r_state  (dbg_r_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: full write transaction. w_lead = cycles W is offered before AW
  // (0 = together). lat = cycles from the last handshake edge to bvalid.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead,
                          output logic [1:0] resp, output int lat,
                          output logic [7:0] pulse0, output logic [7:0] pulse1,
                          output logic irq0);
    bit aw_pend, w_pend, af, wf;
    int cyc;
    axil_awaddr  = addr;
    axil_wdata   = data;
    axil_wstrb   = strb;
    axil_wvalid  = 1'b1;
    axil_awvalid = (w_lead == 0);
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    cyc = 0;
    while ((aw_pend || w_pend) && cyc < 50) begin
      af = axil_awvalid && axil_awready;
      wf = axil_wvalid && axil_wready;
      tick();
      cyc++;
      if (af) begin aw_pend = 1'b0; axil_awvalid = 1'b0; end
      if (wf) begin w_pend = 1'b0; axil_wvalid = 1'b0; end
      if (cyc >= w_lead && aw_pend) axil_awvalid = 1'b1;
    end
    axil_awvalid = 1'b0;
    axil_wvalid  = 1'b0;
    if (cyc >= 50) begin
      n_checks++; n_errors++;
      $display("FAIL wr_handshake_timeout: addr %h not accepted within 50 cycles", addr);
    end
    lat = 0;
    while (!axil_bvalid && lat < 50) begin tick(); lat++; end
    resp   = axil_bresp;
    pulse0 = reg_wr_pulse;
    irq0   = irq;
    axil_bready = 1'b1;
    tick();
    axil_bready = 1'b0;
    pulse1 = reg_wr_pulse;
  endtask

  // Driver: full read transaction.
  task automatic do_read(input logic [7:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int cyc;
    axil_araddr  = addr;
    axil_arvalid = 1'b1;
    cyc = 0;
    while (!axil_arready && cyc < 50) begin tick(); cyc++; end
    tick();
    axil_arvalid = 1'b0;
    cyc = 0;
    while (!axil_rvalid && cyc < 50) begin tick(); cyc++; end
    if (cyc >= 50) begin
      n_checks++; n_errors++;
      $display("FAIL rd_timeout: addr %h no rvalid within 50 cycles", addr);
    end
    data = axil_rdata;
    resp = axil_rresp;
    axil_rready = 1'b1;
    tick();
    axil_rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if ({axil_awready, axil_wready, axil_arready} !== 3'b000) begin n_errors++; $display("FAIL rst_readies: got %b expected 000", {axil_awready, axil_wready, axil_arready}); end
    n_checks++; if ({axil_bvalid, axil_rvalid, irq} !== 3'b000) begin n_errors++; $display("FAIL rst_valids_irq: got %b expected 000", {axil_bvalid, axil_rvalid, irq}); end
    n_checks++; if (reg_q !== 256'h0) begin n_errors++; $display("FAIL rst_reg_q: got %h expected 0", reg_q); end
    n_checks++; if (reg_wr_pulse !== 8'h00) begin n_errors++; $display("FAIL rst_pulse: got %h expected 00", reg_wr_pulse); end
    n_checks++; if ({axil_rdata, axil_rresp, axil_bresp} !== 36'h0) begin n_errors++; $display("FAIL rst_data_resp: got %h expected 0", {axil_rdata, axil_rresp, axil_bresp}); end
    rst_n = 1'b1;
    tick();
    n_checks++; if ({axil_awready, axil_wready, axil_arready} !== 3'b111) begin n_errors++; $display("FAIL rst_release_readies: got %b expected 111", {axil_awready, axil_wready, axil_arready}); end
  endtask

  task automatic test_write_same_cycle();
    logic [1:0] resp; int lat; logic [7:0] p0, p1; logic i0; logic [31:0] rd;
    do_write(8'h00, 32'hDEADBEEF, 4'hF, 0, resp, lat, p0, p1, i0);
    n_checks++; if (resp !== 2'b00) begin n_errors++; $display("FAIL same_bresp: got %b expected 00", resp); end
    n_checks++; if (lat !== 0) begin n_errors++; $display("FAIL same_latency: got %0d expected 0", lat); end
    n_checks++; if (p0 !== 8'h01) begin n_errors++; $display("FAIL same_pulse: got %h expected 01", p0); end
    n_checks++; if (p1 !== 8'h00) begin n_errors++; $display("FAIL same_pulse_clear: got %h expected 00", p1); end
    do_read(8'h00, rd, resp);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL same_readback: got %h expected deadbeef", rd); end
    n_checks++; if (resp !== 2'b00) begin n_errors++; $display("FAIL same_rresp: got %b expected 00", resp); end
  endtask

  task automatic test_write_w_first();
    logic [1:0] resp; int lat; logic [7:0] p0, p1; logic i0; logic [31:0] rd;
    do_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, resp, lat, p0, p1, i0);
    do_write(8'h08, 32'h12345678, 4'h3, 2, resp, lat, p0, p1, i0);
    n_checks++; if (resp !== 2'b00) begin n_errors++; $display("FAIL wfirst_bresp: got %b expected 00", resp); end
    n_checks++; if (lat !== 0) begin n_errors++; $display("FAIL wfirst_latency: got %0d expected 0", lat); end
    n_checks++; if (p0 !== 8'h04) begin n_errors++; $display("FAIL wfirst_pulse: got %h expected 04", p0); end
    n_checks++; if (reg_q[2*32 +: 32] !== 32'hFFFF5678) begin n_errors++; $display("FAIL wfirst_reg_q: got %h expected ffff5678", reg_q[2*32 +: 32]); end
    do_read(8'h08, rd, resp);
    n_checks++; if (rd !== 32'hFFFF5678) begin n_errors++; $display("FAIL wfirst_readback: got %h expected ffff5678", rd); end
  endtask

  task automatic test_ro();
    logic [1:0] resp; int lat; logic [7:0] p0, p1; logic i0; logic [31:0] rd;
    do_write(8'h10, 32'hFFFFFFFF, 4'hF, 0, resp, lat, p0, p1, i0);
    n_checks++; if (resp !== 2'b00) begin n_errors++; $display("FAIL ro_bresp: got %b expected 00", resp); end
    n_checks++; if (reg_q[4*32 +: 32] !== 32'h0) begin n_errors++; $display("FAIL ro_bus_ignored: got %h expected 0", reg_q[4*32 +: 32]); end
    hw_wr = 8'h10;
    hw_wdata[4*32 +: 32] = 32'hA5;
    tick();
    hw_wr = 8'h00;
    hw_wdata = '0;
    n_checks++; if (reg_q[4*32 +: 32] !== 32'hA5) begin n_errors++; $display("FAIL ro_hw_load: got %h expected a5", reg_q[4*32 +: 32]); end
    do_read(8'h10, rd, resp);
    n_checks++; if (rd !== 32'hA5) begin n_errors++; $display("FAIL ro_readback: got %h expected a5", rd); end
  endtask

  task automatic test_w1c_irq();
    logic [1:0] resp; int lat; logic [7:0] p0, p1; logic i0;
    hw_wr = 8'h20;
    hw_wdata[5*32 +: 32] = 32'h3;
    tick();
    hw_wr = 8'h00;
    hw_wdata = '0;
    n_checks++; if (reg_q[5*32 +: 32] !== 32'h3) begin n_errors++; $display("FAIL w1c_hw_set: got %h expected 3", reg_q[5*32 +: 32]); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_disabled: got %b expected 0", irq); end
    do_write(8'h18, 32'h1, 4'hF, 0, resp, lat, p0, p1, i0);
    n_checks++; if (i0 !== 1'b0) begin n_errors++; $display("FAIL irq_lag_rise: got %b expected 0", i0); end
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_enabled: got %b expected 1", irq); end
    // Bus W1C of bit0 on the same edge as a hardware set of bit0.
    axil_awaddr = 8'h14; axil_wdata = 32'h1; axil_wstrb = 4'hF;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    hw_wr = 8'h20; hw_wdata[5*32 +: 32] = 32'h1;
    tick();
    axil_awvalid = 1'b0; axil_wvalid = 1'b0;
    hw_wr = 8'h00; hw_wdata = '0;
    n_checks++; if (axil_bvalid !== 1'b1) begin n_errors++; $display("FAIL w1c_race_bvalid: got %b expected 1", axil_bvalid); end
    n_checks++; if (reg_q[5*32 +: 32] !== 32'h3) begin n_errors++; $display("FAIL w1c_set_wins: got %h expected 3", reg_q[5*32 +: 32]); end
    axil_bready = 1'b1; tick(); axil_bready = 1'b0;
    do_write(8'h14, 32'h3, 4'hF, 0, resp, lat, p0, p1, i0);
    n_checks++; if (i0 !== 1'b1) begin n_errors++; $display("FAIL irq_lag_fall: got %b expected 1", i0); end
    n_checks++; if (reg_q[5*32 +: 32] !== 32'h0) begin n_errors++; $display("FAIL w1c_clear: got %h expected 0", reg_q[5*32 +: 32]); end
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_cleared: got %b expected 0", irq); end
  endtask

  task automatic test_slverr();
    logic [1:0] resp; int lat; logic [7:0] p0, p1; logic i0; logic [31:0] rd;
    do_write(8'h20, 32'hCAFEF00D, 4'hF, 0, resp, lat, p0, p1, i0);
    n_checks++; if (resp !== 2'b10) begin n_errors++; $display("FAIL oor_bresp: got %b expected 10", resp); end
    n_checks++; if (p0 !== 8'h00) begin n_errors++; $display("FAIL oor_pulse: got %h expected 00", p0); end
    do_write(8'h02, 32'h0BADF00D, 4'hF, 0, resp, lat, p0, p1, i0);
    n_checks++; if (resp !== 2'b10) begin n_errors++; $display("FAIL misalign_bresp: got %b expected 10", resp); end
    n_checks++; if (reg_q[0 +: 32] !== 32'hDEADBEEF) begin n_errors++; $display("FAIL misalign_no_write: got %h expected deadbeef", reg_q[0 +: 32]); end
    do_read(8'h20, rd, resp);
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL oor_rdata: got %h expected 0", rd); end
    n_checks++; if (resp !== 2'b10) begin n_errors++; $display("FAIL oor_rresp: got %b expected 10", resp); end
  endtask

  task automatic test_reset_mid();
    // Write and read of reg0 handshake on the same edge.
    axil_awaddr = 8'h00; axil_wdata = 32'h11111111; axil_wstrb = 4'hF;
    axil_awvalid = 1'b1; axil_wvalid = 1'b1;
    axil_araddr = 8'h00; axil_arvalid = 1'b1;
    tick();
    axil_awvalid = 1'b0; axil_wvalid = 1'b0; axil_arvalid = 1'b0;
    n_checks++; if (axil_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL b2b_pre_write_read: got %h expected deadbeef", axil_rdata); end
    n_checks++; if (reg_q[0 +: 32] !== 32'h11111111) begin n_errors++; $display("FAIL b2b_write: got %h expected 11111111", reg_q[0 +: 32]); end
    repeat (5) tick();
    n_checks++; if ({axil_bvalid, axil_rvalid} !== 2'b11) begin n_errors++; $display("FAIL hold_valids: got %b expected 11", {axil_bvalid, axil_rvalid}); end
    n_checks++; if (axil_rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL hold_rdata: got %h expected deadbeef", axil_rdata); end
    rst_n = 1'b0;
    tick();
    n_checks++; if ({axil_bvalid, axil_rvalid} !== 2'b00) begin n_errors++; $display("FAIL midrst_valids: got %b expected 00", {axil_bvalid, axil_rvalid}); end
    n_checks++; if ({axil_awready, axil_wready, axil_arready} !== 3'b000) begin n_errors++; $display("FAIL midrst_readies: got %b expected 000", {axil_awready, axil_wready, axil_arready}); end
    n_checks++; if (reg_q !== 256'h0) begin n_errors++; $display("FAIL midrst_regs: got %h expected 0", reg_q); end
    rst_n = 1'b1;
    tick();
    n_checks++; if ({axil_awready, axil_wready, axil_arready} !== 3'b111) begin n_errors++; $display("FAIL midrst_release: got %b expected 111", {axil_awready, axil_wready, axil_arready}); end
    // W captured, then reset: the captured data must be forgotten.
    axil_wdata = 32'h55; axil_wvalid = 1'b1;
    tick();
    axil_wvalid = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    axil_awaddr = 8'h00; axil_awvalid = 1'b1;
    tick();
    axil_awvalid = 1'b0;
    repeat (2) tick();
    n_checks++; if (axil_bvalid !== 1'b0) begin n_errors++; $display("FAIL discard_no_commit: got bvalid %b expected 0", axil_bvalid); end
    n_checks++; if (reg_q[0 +: 32] !== 32'h0) begin n_errors++; $display("FAIL discard_reg0: got %h expected 0", reg_q[0 +: 32]); end
    axil_wdata = 32'h66; axil_wvalid = 1'b1;
    tick();
    axil_wvalid = 1'b0;
    n_checks++; if ({axil_bvalid, reg_q[0 +: 32]} !== {1'b1, 32'h66}) begin n_errors++; $display("FAIL discard_complete: got %h expected 100000066", {axil_bvalid, reg_q[0 +: 32]}); end
    axil_bready = 1'b1; tick(); axil_bready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    axil_awvalid = 1'b0; axil_awaddr = '0;
    axil_wvalid = 1'b0; axil_wdata = '0; axil_wstrb = '0;
    axil_bready = 1'b0;
    axil_arvalid = 1'b0; axil_araddr = '0;
    axil_rready = 1'b0;
    hw_wr = '0; hw_wdata = '0;
    test_reset();
    test_write_same_cycle();
    test_write_w_first();
    test_ro();
    test_w1c_irq();
    test_slverr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
